// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one single-port memory between instruction fetch and data access.
// Latency: grant at edge k, mem_req from cycle k+1, ack the cycle after mem_ready; one IDLE cycle between transfers.
// Backpressure: one transfer outstanding; the waiting requester is held off via stall_if/stall_mem until its ack.
//
// Ports:
//   clk, reset                      clock, asynchronous active-low reset
//   if_req/if_addr/if_flush         fetch request, PC, taken-branch discard
//   if_rdata/if_ack                 fetched word, one-cycle completion pulse
//   dm_req/dm_we/dm_addr/dm_wdata/dm_funct3   data access request and payload
//   dm_rdata/dm_ack                 load data, one-cycle completion pulse
//   mem_req/mem_we/mem_addr/mem_wdata/mem_funct3   registered request to shared memory
//   mem_rdata/mem_ready             memory read data, transfer-complete strobe
//   stall_if/stall_mem              stall requests to hazard logic
//   busy                            a transfer is outstanding
module mem_port_arbiter #(
   parameter int DW         = 32,
   parameter int MAX_DM_RUN = 4
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          if_req,
   input  logic [DW-1:0] if_addr,
   input  logic          if_flush,
   output logic [DW-1:0] if_rdata,
   output logic          if_ack,
   input  logic          dm_req,
   input  logic          dm_we,
   input  logic [DW-1:0] dm_addr,
   input  logic [DW-1:0] dm_wdata,
   input  logic [2:0]    dm_funct3,
   output logic [DW-1:0] dm_rdata,
   output logic          dm_ack,
   output logic          mem_req,
   output logic          mem_we,
   output logic [DW-1:0] mem_addr,
   output logic [DW-1:0] mem_wdata,
   output logic [2:0]    mem_funct3,
   input  logic [DW-1:0] mem_rdata,
   input  logic          mem_ready,
   output logic          stall_if,
   output logic          stall_mem,
   output logic          busy
);

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      IF_WAIT = 2'd1,
      DM_WAIT = 2'd2
   } state_t;

   localparam logic [2:0] RUN_MAX = 3'(MAX_DM_RUN);

   state_t     state;
   logic [2:0] dm_run;    // data grants in a row while fetch has been requesting
   logic       drop;      // current fetch was flushed; complete it silently

   logic dm_elig;
   logic if_elig;
   logic grant_if;
   logic grant_dm;

   // A requester whose ack is showing this cycle has just been served, so its
   // req is for the next access and may not yet carry a settled payload.
   always_comb begin
      dm_elig  = dm_req & ~dm_ack;
      if_elig  = if_req & ~if_ack & ~if_flush;
      grant_if = (state == IDLE) & if_elig & (~dm_elig | (dm_run == RUN_MAX));
      grant_dm = (state == IDLE) & dm_elig & ~grant_if;
   end

   assign stall_if  = if_req & ~if_ack;
   assign stall_mem = dm_req & ~dm_ack;
   assign busy      = (state != IDLE);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state      <= IDLE;
         mem_req    <= 1'b0;
         mem_we     <= 1'b0;
         mem_addr   <= '0;
         mem_wdata  <= '0;
         mem_funct3 <= 3'b000;
         if_ack     <= 1'b0;
         dm_ack     <= 1'b0;
         if_rdata   <= '0;
         dm_rdata   <= '0;
         dm_run     <= 3'd0;
         drop       <= 1'b0;
      end else begin
         if_ack <= 1'b0;
         dm_ack <= 1'b0;

         // Fairness counter only matters while fetch is actually waiting.
         if (!if_req || grant_if) begin
            dm_run <= 3'd0;
         end else if (grant_dm && (dm_run < RUN_MAX)) begin
            dm_run <= dm_run + 3'd1;
         end

         case (state)
            IDLE: begin
               drop <= 1'b0;
               if (grant_if) begin
                  state      <= IF_WAIT;
                  mem_req    <= 1'b1;
                  mem_we     <= 1'b0;
                  mem_addr   <= if_addr;
                  mem_wdata  <= '0;
                  mem_funct3 <= 3'b010;
               end else if (grant_dm) begin
                  state      <= DM_WAIT;
                  mem_req    <= 1'b1;
                  mem_we     <= dm_we;
                  mem_addr   <= dm_addr;
                  mem_wdata  <= dm_wdata;
                  mem_funct3 <= dm_funct3;
               end
            end
            IF_WAIT: begin
               if (mem_ready) begin
                  state   <= IDLE;
                  mem_req <= 1'b0;
                  drop    <= 1'b0;
                  // A flush landing on the completing cycle also discards the word.
                  if (!(drop || if_flush)) begin
                     if_ack   <= 1'b1;
                     if_rdata <= mem_rdata;
                  end
               end else if (if_flush) begin
                  drop <= 1'b1;
               end
            end
            DM_WAIT: begin
               if (mem_ready) begin
                  state    <= IDLE;
                  mem_req  <= 1'b0;
                  dm_ack   <= 1'b1;
                  dm_rdata <= mem_rdata;
               end
            end
            default: begin
               state   <= IDLE;
               mem_req <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: directed scenarios plus a randomized run against a transaction-level model.
// Latency: inputs driven at the falling edge, outputs sampled 1 ns later.
// Backpressure: bench requesters hold req/payload until their ack, as a pipeline would.
module tb_mem_port_arbiter;

   localparam int DW   = 32;
   localparam int MAXR = 4;

   logic          clk = 1'b0;
   logic          reset;
   logic          if_req, if_flush, if_ack;
   logic [DW-1:0] if_addr, if_rdata;
   logic          dm_req, dm_we, dm_ack;
   logic [DW-1:0] dm_addr, dm_wdata, dm_rdata;
   logic [2:0]    dm_funct3;
   logic          mem_req, mem_we, mem_ready;
   logic [DW-1:0] mem_addr, mem_wdata, mem_rdata;
   logic [2:0]    mem_funct3;
   logic          stall_if, stall_mem, busy;

   int checks = 0;
   int errors = 0;
   logic [DW-1:0] last_if_rdata;

   // Transaction-level reference: who owns the memory and what was handed to it.
   int            owner;      // 0 none, 1 fetch, 2 data
   logic [DW-1:0] x_addr, x_wdata;
   logic          x_we;
   logic [2:0]    x_f3;
   logic          flushed;
   int            run;
   logic          e_if_ack, e_dm_ack;
   logic [DW-1:0] e_if_rdata, e_dm_rdata;

   always #5 clk = ~clk;

   mem_port_arbiter #(.DW(DW), .MAX_DM_RUN(MAXR)) dut (
      .clk(clk), .reset(reset),
      .if_req(if_req), .if_addr(if_addr), .if_flush(if_flush),
      .if_rdata(if_rdata), .if_ack(if_ack),
      .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata), .dm_funct3(dm_funct3),
      .dm_rdata(dm_rdata), .dm_ack(dm_ack),
      .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_funct3(mem_funct3),
      .mem_rdata(mem_rdata), .mem_ready(mem_ready),
      .stall_if(stall_if), .stall_mem(stall_mem), .busy(busy)
   );

   task automatic idle_inputs();
      if_req = 1'b0; if_addr = '0; if_flush = 1'b0;
      dm_req = 1'b0; dm_we = 1'b0; dm_addr = '0; dm_wdata = '0; dm_funct3 = 3'b000;
      mem_ready = 1'b0; mem_rdata = '0;
   endtask

   task automatic model_reset();
      owner = 0; x_addr = '0; x_wdata = '0; x_we = 1'b0; x_f3 = 3'b000;
      flushed = 1'b0; run = 0; e_if_ack = 1'b0; e_dm_ack = 1'b0;
      e_if_rdata = '0; e_dm_rdata = '0;
   endtask

   // Advance the model across the coming rising edge using the inputs now applied.
   task automatic model_step();
      logic gf, gd, de, fe, n_if_ack, n_dm_ack;
      gf = 1'b0; gd = 1'b0; n_if_ack = 1'b0; n_dm_ack = 1'b0;
      if (owner == 0) begin
         de = dm_req && !e_dm_ack;
         fe = if_req && !e_if_ack && !if_flush;
         if (fe && (!de || run == MAXR)) gf = 1'b1;
         else if (de) gd = 1'b1;
         if (gf) begin owner = 1; x_addr = if_addr; x_we = 1'b0; x_f3 = 3'b010; end
         if (gd) begin owner = 2; x_addr = dm_addr; x_we = dm_we; x_wdata = dm_wdata; x_f3 = dm_funct3; end
      end else if (mem_ready) begin
         if (owner == 1) begin
            if (!(flushed || if_flush)) begin n_if_ack = 1'b1; e_if_rdata = mem_rdata; end
         end else begin
            n_dm_ack = 1'b1; e_dm_rdata = mem_rdata;
         end
         owner = 0; flushed = 1'b0;
      end else if (owner == 1 && if_flush) begin
         flushed = 1'b1;
      end
      if (!if_req || gf) run = 0;
      else if (gd && run < MAXR) run = run + 1;
      e_if_ack = n_if_ack; e_dm_ack = n_dm_ack;
   endtask

   task automatic test_reset();
      reset = 1'b0; idle_inputs();
      repeat (2) @(negedge clk);
      #1;
      checks++; if ({mem_req, mem_we, if_ack, dm_ack, busy, stall_if, stall_mem} !== 7'b0) begin
         errors++; $display("FAIL reset_ctrl got=%b exp=0000000", {mem_req, mem_we, if_ack, dm_ack, busy, stall_if, stall_mem}); end
      checks++; if ({mem_addr, mem_wdata, mem_funct3} !== '0) begin
         errors++; $display("FAIL reset_payload got=%h/%h/%b exp=0", mem_addr, mem_wdata, mem_funct3); end
      checks++; if ({if_rdata, dm_rdata} !== '0) begin
         errors++; $display("FAIL reset_rdata got=%h/%h exp=0", if_rdata, dm_rdata); end
      @(negedge clk); reset = 1'b1;
      last_if_rdata = '0;
   endtask

   task automatic test_fetch_only();
      @(negedge clk); if_req = 1'b1; if_addr = 32'h100; #1;
      checks++; if (stall_if !== 1'b1) begin errors++; $display("FAIL fo_stall got=%b exp=1", stall_if); end
      @(negedge clk); #1;
      checks++; if ({mem_req, mem_we, mem_funct3, mem_addr} !== {1'b1, 1'b0, 3'b010, 32'h100}) begin
         errors++; $display("FAIL fo_req got=%b/%b/%b/%h exp=1/0/010/100", mem_req, mem_we, mem_funct3, mem_addr); end
      @(negedge clk); mem_ready = 1'b1; mem_rdata = 32'h0050_0093; #1;
      checks++; if (if_ack !== 1'b0) begin errors++; $display("FAIL fo_early_ack got=%b exp=0", if_ack); end
      @(negedge clk); mem_ready = 1'b0; #1;
      checks++; if ({if_ack, mem_req, busy} !== 3'b100 || if_rdata !== 32'h0050_0093) begin
         errors++; $display("FAIL fo_ack got=%b%b%b %h exp=100 00500093", if_ack, mem_req, busy, if_rdata); end
      last_if_rdata = 32'h0050_0093;
      if_req = 1'b0;
      // mem_ready while idle must be ignored
      @(negedge clk); mem_ready = 1'b1; mem_rdata = 32'hFFFF_FFFF; #1;
      checks++; if (if_ack !== 1'b0 || if_rdata !== last_if_rdata) begin
         errors++; $display("FAIL fo_pulse got=%b %h exp=0 %h", if_ack, if_rdata, last_if_rdata); end
      @(negedge clk); mem_ready = 1'b0; #1;
      checks++; if ({if_ack, dm_ack, mem_req, busy} !== 4'b0 || dm_rdata !== 32'h0) begin
         errors++; $display("FAIL fo_idle_ready got=%b%b%b%b %h exp=0000 0", if_ack, dm_ack, mem_req, busy, dm_rdata); end
   endtask

   task automatic test_simultaneous();
      @(negedge clk);
      if_req = 1'b1; if_addr = 32'h180;
      dm_req = 1'b1; dm_we = 1'b1; dm_addr = 32'h200; dm_wdata = 32'hDEAD_BEEF; dm_funct3 = 3'b010;
      #1;
      checks++; if ({stall_if, stall_mem} !== 2'b11) begin errors++; $display("FAIL sim_stall0 got=%b exp=11", {stall_if, stall_mem}); end
      @(negedge clk); mem_ready = 1'b1; mem_rdata = 32'h1111_1111; #1;
      checks++; if ({mem_req, mem_we, mem_addr, mem_wdata, stall_if} !== {1'b1, 1'b1, 32'h200, 32'hDEAD_BEEF, 1'b1}) begin
         errors++; $display("FAIL sim_data_first got=%b/%b/%h/%h/%b exp=1/1/200/deadbeef/1", mem_req, mem_we, mem_addr, mem_wdata, stall_if); end
      @(negedge clk); mem_ready = 1'b0; #1;
      checks++; if ({dm_ack, mem_req, stall_if} !== 3'b101 || dm_rdata !== 32'h1111_1111) begin
         errors++; $display("FAIL sim_dm_ack got=%b%b%b %h exp=101 11111111", dm_ack, mem_req, stall_if, dm_rdata); end
      dm_req = 1'b0;
      @(negedge clk); mem_ready = 1'b1; mem_rdata = 32'h2222_2222; #1;
      checks++; if ({mem_req, mem_we, mem_addr, stall_if} !== {1'b1, 1'b0, 32'h180, 1'b1}) begin
         errors++; $display("FAIL sim_fetch_next got=%b/%b/%h/%b exp=1/0/180/1", mem_req, mem_we, mem_addr, stall_if); end
      @(negedge clk); mem_ready = 1'b0; #1;
      checks++; if ({if_ack, stall_if} !== 2'b10 || if_rdata !== 32'h2222_2222) begin
         errors++; $display("FAIL sim_if_ack got=%b%b %h exp=10 22222222", if_ack, stall_if, if_rdata); end
      last_if_rdata = 32'h2222_2222;
      if_req = 1'b0;
      @(negedge clk); #1;
   endtask

   task automatic test_starvation();
      // Fetch is kept ineligible during each data-ack cycle with a flush so that
      // data wins every contested slot until the run limit forces fetch in.
      @(negedge clk);
      if_req = 1'b1; if_addr = 32'h400;
      dm_req = 1'b1; dm_we = 1'b0; dm_addr = 32'h500; dm_funct3 = 3'b010;
      for (int i = 0; i < MAXR; i++) begin
         @(negedge clk); mem_ready = 1'b1; mem_rdata = 32'(i + 7); #1;
         checks++; if ({mem_req, mem_we, mem_addr} !== {1'b1, 1'b0, 32'(32'h500 + 4 * i)}) begin
            errors++; $display("FAIL starve_dgrant%0d got=%b/%b/%h exp=1/0/%h", i, mem_req, mem_we, mem_addr, 32'h500 + 4 * i); end
         @(negedge clk); mem_ready = 1'b0; if_flush = 1'b1; dm_addr = 32'(32'h500 + 4 * (i + 1)); #1;
         checks++; if (dm_ack !== 1'b1 || dm_rdata !== 32'(i + 7)) begin
            errors++; $display("FAIL starve_dack%0d got=%b %h exp=1 %h", i, dm_ack, dm_rdata, i + 7); end
         @(negedge clk); if_flush = 1'b0;
      end
      #1;
      checks++; if (dut.dm_run !== 3'(MAXR)) begin errors++; $display("FAIL starve_run_sat got=%0d exp=%0d", dut.dm_run, MAXR); end
      @(negedge clk); mem_ready = 1'b1; mem_rdata = 32'hA5A5_0001; #1;
      checks++; if ({mem_req, mem_we, mem_addr} !== {1'b1, 1'b0, 32'h400}) begin
         errors++; $display("FAIL starve_fetch_wins got=%b/%b/%h exp=1/0/400", mem_req, mem_we, mem_addr); end
      checks++; if (dut.dm_run !== 3'd0) begin errors++; $display("FAIL starve_run_clr got=%0d exp=0", dut.dm_run); end
      @(negedge clk); mem_ready = 1'b0; #1;
      checks++; if (if_ack !== 1'b1 || if_rdata !== 32'hA5A5_0001) begin
         errors++; $display("FAIL starve_if_ack got=%b %h exp=1 a5a50001", if_ack, if_rdata); end
      last_if_rdata = 32'hA5A5_0001;
      if_req = 1'b0;
      @(negedge clk); mem_ready = 1'b1; mem_rdata = 32'h0000_0B0B; #1;
      checks++; if ({mem_req, mem_addr} !== {1'b1, 32'h510}) begin
         errors++; $display("FAIL starve_data_after got=%b/%h exp=1/510", mem_req, mem_addr); end
      @(negedge clk); mem_ready = 1'b0; #1;
      dm_req = 1'b0;
      @(negedge clk); #1;
   endtask

   task automatic test_flush();
      @(negedge clk); if_req = 1'b1; if_addr = 32'h104;
      @(negedge clk); if_flush = 1'b1; if_addr = 32'h200; #1;
      checks++; if ({mem_req, mem_addr} !== {1'b1, 32'h104}) begin
         errors++; $display("FAIL fl_req got=%b/%h exp=1/104", mem_req, mem_addr); end
      @(negedge clk); if_flush = 1'b0; #1;
      checks++; if ({mem_req, mem_addr} !== {1'b1, 32'h104}) begin
         errors++; $display("FAIL fl_hold got=%b/%h exp=1/104", mem_req, mem_addr); end
      @(negedge clk);
      @(negedge clk); mem_ready = 1'b1; mem_rdata = 32'hBAD0_BAD0;
      @(negedge clk); mem_ready = 1'b0; #1;
      checks++; if ({if_ack, mem_req, busy} !== 3'b000 || if_rdata !== last_if_rdata) begin
         errors++; $display("FAIL fl_dropped got=%b%b%b %h exp=000 %h", if_ack, mem_req, busy, if_rdata, last_if_rdata); end
      @(negedge clk); mem_ready = 1'b1; mem_rdata = 32'h0000_0013; #1;
      checks++; if ({mem_req, mem_we, mem_addr} !== {1'b1, 1'b0, 32'h200}) begin
         errors++; $display("FAIL fl_next_req got=%b/%b/%h exp=1/0/200", mem_req, mem_we, mem_addr); end
      @(negedge clk); mem_ready = 1'b0; #1;
      checks++; if (if_ack !== 1'b1 || if_rdata !== 32'h0000_0013) begin
         errors++; $display("FAIL fl_next_ack got=%b %h exp=1 00000013", if_ack, if_rdata); end
      last_if_rdata = 32'h0000_0013;
      if_req = 1'b0;
      @(negedge clk); #1;
   endtask

   task automatic test_wait_states();
      int acks;
      acks = 0;
      @(negedge clk); dm_req = 1'b1; dm_we = 1'b0; dm_addr = 32'h600; dm_funct3 = 3'b100;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk); #1;
         checks++; if ({mem_req, mem_addr, mem_funct3} !== {1'b1, 32'h600, 3'b100}) begin
            errors++; $display("FAIL ws_hold%0d got=%b/%h/%b exp=1/600/100", i, mem_req, mem_addr, mem_funct3); end
         if (dm_ack) acks++;
      end
      @(negedge clk); mem_ready = 1'b1; mem_rdata = 32'hCAFE_0042; #1;
      checks++; if ({mem_req, mem_addr} !== {1'b1, 32'h600}) begin
         errors++; $display("FAIL ws_ready_cycle got=%b/%h exp=1/600", mem_req, mem_addr); end
      for (int i = 0; i < 4; i++) begin
         @(negedge clk); mem_ready = (i != 0); #1;
         if (i == 0) begin
            checks++; if (dm_ack !== 1'b1 || dm_rdata !== 32'hCAFE_0042) begin
               errors++; $display("FAIL ws_ack got=%b %h exp=1 cafe0042", dm_ack, dm_rdata); end
            dm_req = 1'b0;
         end
         if (dm_ack) acks++;
      end
      mem_ready = 1'b0;
      checks++; if (acks !== 1) begin errors++; $display("FAIL ws_ack_count got=%0d exp=1", acks); end
      checks++; if ({mem_req, busy} !== 2'b00) begin errors++; $display("FAIL ws_idle got=%b exp=00", {mem_req, busy}); end
   endtask

   task automatic test_reset_mid();
      @(negedge clk); dm_req = 1'b1; dm_we = 1'b1; dm_addr = 32'h700; dm_wdata = 32'h1234_5678; dm_funct3 = 3'b000;
      @(negedge clk); mem_ready = 1'b1; mem_rdata = 32'h55; #1;
      checks++; if ({mem_req, busy} !== 2'b11) begin errors++; $display("FAIL rm_pre got=%b exp=11", {mem_req, busy}); end
      #1 reset = 1'b0; #1;
      checks++; if ({mem_req, busy, dm_ack, mem_we} !== 4'b0000 || mem_addr !== 32'h0) begin
         errors++; $display("FAIL rm_async got=%b %h exp=0000 0", {mem_req, busy, dm_ack, mem_we}, mem_addr); end
      @(negedge clk); #1;
      checks++; if (dm_ack !== 1'b0 || dm_rdata !== 32'h0) begin
         errors++; $display("FAIL rm_no_ack got=%b %h exp=0 0", dm_ack, dm_rdata); end
      @(negedge clk); reset = 1'b1; mem_ready = 1'b0; #1;
      last_if_rdata = '0;
      @(negedge clk); mem_ready = 1'b1; mem_rdata = 32'h66; #1;
      checks++; if ({mem_req, mem_we, mem_addr} !== {1'b1, 1'b1, 32'h700}) begin
         errors++; $display("FAIL rm_first_grant got=%b/%b/%h exp=1/1/700", mem_req, mem_we, mem_addr); end
      @(negedge clk); mem_ready = 1'b0; #1;
      checks++; if (dm_ack !== 1'b1 || dm_rdata !== 32'h66) begin
         errors++; $display("FAIL rm_after_ack got=%b %h exp=1 66", dm_ack, dm_rdata); end
      dm_req = 1'b0;
      @(negedge clk); #1;
   endtask

   task automatic test_random();
      logic exp_busy;
      @(negedge clk); reset = 1'b0; idle_inputs(); model_reset();
      @(negedge clk); reset = 1'b1;
      for (int c = 0; c < 3000; c++) begin
         @(negedge clk);
         if_flush = 1'b0;
         if (!if_req || e_if_ack) begin if_req = (($urandom % 4) != 0); if_addr = $urandom & 32'hFFFF_FFFC; end
         if (($urandom % 12) == 0) begin if_flush = 1'b1; if_addr = $urandom & 32'hFFFF_FFFC; end
         if (!dm_req || e_dm_ack) begin
            dm_req = (($urandom % 3) != 0); dm_we = 1'($urandom % 2);
            dm_addr = $urandom; dm_wdata = $urandom; dm_funct3 = 3'($urandom % 8);
         end
         mem_ready = (($urandom % 3) == 0); mem_rdata = $urandom;
         #1;
         exp_busy = (owner != 0);
         checks++; if ({mem_req, busy} !== {exp_busy, exp_busy}) begin
            errors++; $display("FAIL rnd_busy c=%0d got=%b exp=%b", c, {mem_req, busy}, {exp_busy, exp_busy}); end
         checks++; if ({if_ack, dm_ack} !== {e_if_ack, e_dm_ack}) begin
            errors++; $display("FAIL rnd_ack c=%0d got=%b exp=%b", c, {if_ack, dm_ack}, {e_if_ack, e_dm_ack}); end
         checks++; if (if_rdata !== e_if_rdata || dm_rdata !== e_dm_rdata) begin
            errors++; $display("FAIL rnd_rdata c=%0d got=%h/%h exp=%h/%h", c, if_rdata, dm_rdata, e_if_rdata, e_dm_rdata); end
         checks++; if ({stall_if, stall_mem} !== {if_req & ~e_if_ack, dm_req & ~e_dm_ack}) begin
            errors++; $display("FAIL rnd_stall c=%0d got=%b exp=%b", c, {stall_if, stall_mem}, {if_req & ~e_if_ack, dm_req & ~e_dm_ack}); end
         if (exp_busy) begin
            checks++; if ({mem_addr, mem_we, mem_funct3} !== {x_addr, x_we, x_f3}) begin
               errors++; $display("FAIL rnd_payload c=%0d got=%h/%b/%b exp=%h/%b/%b", c, mem_addr, mem_we, mem_funct3, x_addr, x_we, x_f3); end
            if (owner == 2) begin
               checks++; if (mem_wdata !== x_wdata) begin
                  errors++; $display("FAIL rnd_wdata c=%0d got=%h exp=%h", c, mem_wdata, x_wdata); end
            end
         end
         model_step();
      end
   endtask

   initial begin
      test_reset();
      test_fetch_only();
      test_simultaneous();
      test_starvation();
      test_flush();
      test_wait_states();
      test_reset_mid();
      test_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/mem_port_arbiter.md
MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 Parameter: DW, 32, data/address width.
REQ-002 Parameter: MAX_DM_RUN, 4, max consecutive data grants while fetch is waiting.
REQ-003 Port: clk  input  1  single clock; all state updates on rising edge.
REQ-004 Port: reset  input  1  asynchronous, active-low reset.
REQ-005 Port: if_req, if_addr  input  1, DW  fetch-stage read request and PC.
REQ-006 Port: if_flush  input  1  taken branch/jump; pending fetch is discarded.
REQ-007 Port: if_rdata, if_ack  output  DW, 1  fetched instruction and 1-cycle completion pulse.
REQ-008 Port: dm_req, dm_we, dm_addr, dm_wdata, dm_funct3  input  1, 1, DW, DW, 3  memory-stage access (funct3 = size/sign).
REQ-009 Port: dm_rdata, dm_ack  output  DW, 1  load data and 1-cycle completion pulse.
REQ-010 Port: mem_req, mem_we, mem_addr, mem_wdata, mem_funct3  output  1, 1, DW, DW, 3  shared single-port memory request.
REQ-011 Port: mem_rdata, mem_ready  input  DW, 1  memory read data and transfer-complete strobe.
REQ-012 Port: stall_if, stall_mem  output  1, 1  pipeline stall requests to hazard logic.
REQ-013 Port: busy  output  1  high whenever state is not IDLE.

Function
REQ-014 FSM states SHALL be IDLE, IF_WAIT, DM_WAIT; only one transaction outstanding at any time.
REQ-015 In IDLE, eligible requesters are dm_req (unless dm_ack is high this cycle) and if_req (unless if_ack or if_flush is high this cycle).
REQ-016 Arbitration SHALL grant data over fetch, except fetch wins when both are eligible and dm_run == MAX_DM_RUN.
REQ-017 dm_run (3-bit) SHALL increment on each data grant while if_req is high, saturate at MAX_DM_RUN, and clear on every fetch grant or whenever if_req is low.
REQ-018 On a grant, the arbiter SHALL register the requester's address/we/wdata/funct3 into the mem_* outputs and assert mem_req from the next cycle; fetch grants drive mem_we=0, mem_funct3=3'b010.
REQ-019 mem_req and all mem_* payload SHALL stay constant from assertion until the cycle mem_ready is sampled high, inclusive.
REQ-020 On the edge where mem_ready=1 in X_WAIT: mem_req->0, rdata registered into the granted requester's *_rdata, *_ack pulses high for exactly one cycle, state->IDLE.
REQ-021 Minimum latency: request sampled at edge k, mem_req high in cycle k+1, with mem_ready in cycle k+1, ack in cycle k+2; one IDLE cycle between transactions.
REQ-022 mem_ready SHALL be ignored in IDLE.
REQ-023 if_flush in IF_WAIT SHALL set a drop flag; the memory transfer completes normally but if_ack stays 0 and if_rdata is unchanged; flag clears on return to IDLE.
REQ-024 Write grants return dm_ack like reads; dm_rdata is updated with mem_rdata regardless.
REQ-025 stall_if = if_req & ~if_ack; stall_mem = dm_req & ~dm_ack (combinational).
REQ-026 Requesters hold req and payload stable until ack; payload changes before ack are not required to be honored.

Reset
REQ-027 On reset low, asynchronously: state=IDLE, mem_req=0, mem_we=0, mem_addr/mem_wdata/mem_funct3=0, if_ack=dm_ack=0, if_rdata=dm_rdata=0, dm_run=0, drop flag=0, busy=0.
REQ-028 Reset mid-transaction SHALL abandon it with no ack; first grant possible in the first cycle after reset releases.

Verification
REQ-029 Fetch only: if_req=1, if_addr=0x100, mem_ready one cycle after mem_req, mem_rdata=0x00500093 -> mem_addr=0x100, mem_we=0, if_ack one cycle, if_rdata=0x00500093.
REQ-030 Simultaneous: if_req and dm_req (store 0x200, wdata 0xDEADBEEF) both rise together -> data granted first (mem_we=1, mem_addr=0x200), fetch granted next, stall_if high throughout.
REQ-031 Starvation: dm_req held continuously, if_req held -> after 4 data grants the 5th grant goes to fetch, then dm_run=0.
REQ-032 Flush: fetch 0x104 in IF_WAIT, if_flush pulsed, mem_ready after 3 cycles -> no if_ack, if_rdata unchanged, next fetch 0x200 served normally.
REQ-033 Wait states: mem_ready held low 5 cycles -> mem_req/mem_addr stable all 5 cycles, ack exactly once.
REQ-034 Reset asserted in DM_WAIT -> mem_req=0 immediately (same cycle), no dm_ack, busy=0.
